minibyte_bus_arbiter: RTL and testbench

Shares the 7-bit address / 8-bit data external memory bus between two requesters: the minibyte CPU port and a debug/host loader port. It runs one bus transaction at a time through a fixed address-setup / access / response sequence. The access phase has a parameterised number of wait states, so slow external memory and the onboard ROM/register RAM can sit behind a single timing model. It sits between the requesters and the top-level address, WE, data and output-enable pins.

---
 rtl/minibyte_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_minibyte_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minibyte_bus_arbiter.sv
// Round-robin arbiter sharing the external 7-bit address / 8-bit data bus between
// the CPU port and the debug loader port, one ADDR/ACCESS/RESP transaction at a time.
module minibyte_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [6:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [6:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] rdata,
    output logic [6:0] bus_addr,
    output logic       bus_we,
    output logic [7:0] bus_wdata,
    output logic       bus_oe,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     r_state;
    state_t     w_next_state;
    owner_t     r_owner;
    owner_t     r_last_grant;
    logic       r_we;
    logic [3:0] r_cnt;

    logic       w_start;
    logic       w_grant_cpu;
    logic       w_bus_we_nxt;
    logic       w_bus_oe_nxt;
    logic       w_cpu_ack_nxt;
    logic       w_dbg_ack_nxt;
    logic       w_busy_nxt;

    assign w_start     = cpu_req | dbg_req;
    assign w_grant_cpu = cpu_req & (~dbg_req | (r_last_grant == OWN_DBG));

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = ADDR;
            ADDR:    w_next_state = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_comb begin
        w_bus_we_nxt  = 1'b0;
        w_bus_oe_nxt  = 1'b0;
        w_cpu_ack_nxt = 1'b0;
        w_dbg_ack_nxt = 1'b0;
        w_busy_nxt    = (w_next_state != IDLE);
        if (w_next_state == ACCESS) begin
            w_bus_we_nxt = r_we;
            w_bus_oe_nxt = r_we;
        end
        if (w_next_state == RESP) begin
            w_cpu_ack_nxt = (r_owner == OWN_CPU);
            w_dbg_ack_nxt = (r_owner == OWN_DBG);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus_we  <= 1'b0;
            bus_oe  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            busy    <= 1'b0;
        end else begin
            bus_we  <= w_bus_we_nxt;
            bus_oe  <= w_bus_oe_nxt;
            cpu_ack <= w_cpu_ack_nxt;
            dbg_ack <= w_dbg_ack_nxt;
            busy    <= w_busy_nxt;
        end
    end

    // bus_addr/bus_wdata double as the latched request copies: loaded at grant, held after.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_owner      <= OWN_CPU;
            r_last_grant <= OWN_DBG;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            rdata        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_owner      <= w_grant_cpu ? OWN_CPU : OWN_DBG;
                        r_last_grant <= w_grant_cpu ? OWN_CPU : OWN_DBG;
                        r_we         <= w_grant_cpu ? cpu_we : dbg_we;
                        bus_addr     <= w_grant_cpu ? cpu_addr : dbg_addr;
                        bus_wdata    <= w_grant_cpu ? cpu_wdata : dbg_wdata;
                    end
                end
                ADDR: r_cnt <= WAIT_LOAD;
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!r_we) begin
                        rdata <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Directed bench: per-cycle vector table for the default-timing arbiter, plus hand
// sequences for abort, late input changes and the WAIT_CYCLES=0/15 latency variants.
module tb_minibyte_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [6:0] cpu_addr = '0, dbg_addr = '0;
    logic [7:0] cpu_wdata = '0, dbg_wdata = '0, bus_rdata = '0;
    logic       cpu_ack, dbg_ack, bus_we, bus_oe, busy;
    logic [7:0] rdata, bus_wdata;
    logic [6:0] bus_addr;

    logic       l_zero = 1'b0;
    logic [6:0] l_zaddr = '0;
    logic [7:0] l_zdata = '0;
    logic       l_req0 = 1'b0, l_req15 = 1'b0;
    logic [6:0] l_addr = 7'h4A;
    logic [7:0] l_brd = 8'h4E;
    logic       cack0, dack0, we0, oe0, busy0, cack15, dack15, we15, oe15, busy15;
    logic [7:0] rdata0, wd0, rdata15, wd15;
    logic [6:0] addr0, addr15;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minibyte_bus_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk_in(clk), .rst_in(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .rdata(rdata), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_oe(bus_oe),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    minibyte_bus_arbiter #(.WAIT_CYCLES(0)) u_dut0 (
        .clk_in(clk), .rst_in(rst_n),
        .cpu_req(l_zero), .cpu_we(l_zero), .cpu_addr(l_zaddr), .cpu_wdata(l_zdata), .cpu_ack(cack0),
        .dbg_req(l_req0), .dbg_we(l_zero), .dbg_addr(l_addr), .dbg_wdata(l_zdata), .dbg_ack(dack0),
        .rdata(rdata0), .bus_addr(addr0), .bus_we(we0), .bus_wdata(wd0), .bus_oe(oe0),
        .bus_rdata(l_brd), .busy(busy0)
    );

    minibyte_bus_arbiter #(.WAIT_CYCLES(15)) u_dut15 (
        .clk_in(clk), .rst_in(rst_n),
        .cpu_req(l_zero), .cpu_we(l_zero), .cpu_addr(l_zaddr), .cpu_wdata(l_zdata), .cpu_ack(cack15),
        .dbg_req(l_req15), .dbg_we(l_zero), .dbg_addr(l_addr), .dbg_wdata(l_zdata), .dbg_ack(dack15),
        .rdata(rdata15), .bus_addr(addr15), .bus_we(we15), .bus_wdata(wd15), .bus_oe(oe15),
        .bus_rdata(l_brd), .busy(busy15)
    );

    typedef struct {
        logic       rst;
        logic       creq, cwe;
        logic [6:0] caddr;
        logic [7:0] cwd;
        logic       dreq, dwe;
        logic [6:0] daddr;
        logic [7:0] dwd;
        logic [7:0] brd;
        logic       eca, eda;
        logic [7:0] erd;
        logic [6:0] eaddr;
        logic       ewe, eoe;
        logic [7:0] ewd;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic rst, input logic creq, input logic cwe, input logic [6:0] caddr, input logic [7:0] cwd,
        input logic dreq, input logic dwe, input logic [6:0] daddr, input logic [7:0] dwd, input logic [7:0] brd,
        input logic eca, input logic eda, input logic [7:0] erd, input logic [6:0] eaddr,
        input logic ewe, input logic eoe, input logic [7:0] ewd, input logic ebusy);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.brd = brd;
        v.eca = eca; v.eda = eda; v.erd = erd; v.eaddr = eaddr;
        v.ewe = ewe; v.eoe = eoe; v.ewd = ewd; v.ebusy = ebusy;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Bus invariants on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((cpu_ack && dbg_ack) || (bus_oe && !bus_we)) begin
                errors++;
                $display("FAIL invariant: cpu_ack=%b dbg_ack=%b bus_oe=%b bus_we=%b", cpu_ack, dbg_ack, bus_oe, bus_we);
            end
        end
    end

    task automatic measure(input bit big, output int n, output logic [7:0] rd);
        n = 0;
        @(negedge clk);
        if (big) l_req15 = 1'b1; else l_req0 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (big ? dack15 : dack0) break;
        end
        rd = big ? rdata15 : rdata0;
        @(negedge clk);
        l_req0 = 1'b0;
        l_req15 = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        bit addr_ok;
        logic [7:0] rd;

        //  rst cq cw ca     cd     dq dw da     dd     brd   | ca da rd     addr   we oe wd     busy
        add(1, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h00, 0, 0, 8'h00, 0);
        add(1, 1, 0, 7'h7C, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h7C, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h7C, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h7C, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h7C, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h7C, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h7C, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  1, 0, 8'hA5, 7'h7C, 0, 0, 8'h00, 1);
        add(1, 0, 0, 7'h7C, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'hA5, 7'h00, 0, 0, 8'h00, 0);
        add(1, 1, 1, 7'h10, 8'h3C, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'hA5, 7'h10, 0, 0, 8'h00, 1);
        add(1, 1, 1, 7'h10, 8'h3C, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'hA5, 7'h10, 1, 1, 8'h3C, 1);
        add(1, 1, 1, 7'h10, 8'h3C, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'hA5, 7'h10, 1, 1, 8'h3C, 1);
        add(1, 1, 1, 7'h10, 8'h3C, 0, 0, 7'h00, 8'h00, 8'hA5,  1, 0, 8'hA5, 7'h10, 0, 0, 8'h00, 1);
        add(1, 0, 0, 7'h10, 8'h3C, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'hA5, 7'h00, 0, 0, 8'h00, 0);
        add(0, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h00, 0, 0, 8'h00, 0);
        add(1, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 8'hA5,  0, 0, 8'h00, 7'h00, 0, 0, 8'h00, 0);
        // both held: CPU, DBG, CPU, DBG with an IDLE cycle between
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h00, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h00, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h00, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  1, 0, 8'h5A, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h5A, 7'h00, 0, 0, 8'h00, 0);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h5A, 7'h02, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h5A, 7'h02, 1, 1, 8'h77, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h5A, 7'h02, 1, 1, 8'h77, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 1, 8'h5A, 7'h02, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'h5A,  0, 0, 8'h5A, 7'h00, 0, 0, 8'h00, 0);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'h5A, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'h5A, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'h5A, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  1, 0, 8'hC3, 7'h01, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'hC3, 7'h00, 0, 0, 8'h00, 0);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'hC3, 7'h02, 0, 0, 8'h00, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'hC3, 7'h02, 1, 1, 8'h77, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 0, 8'hC3, 7'h02, 1, 1, 8'h77, 1);
        add(1, 1, 0, 7'h01, 8'h00, 1, 1, 7'h02, 8'h77, 8'hC3,  0, 1, 8'hC3, 7'h02, 0, 0, 8'h00, 1);
        add(1, 0, 0, 7'h00, 8'h00, 0, 0, 7'h00, 8'h00, 8'hC3,  0, 0, 8'hC3, 7'h00, 0, 0, 8'h00, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_acks", {30'd0, cpu_ack, dbg_ack}, 32'd0);
        chk("reset_we_oe", {30'd0, bus_we, bus_oe}, 32'd0);
        chk("reset_addr", {25'd0, bus_addr}, 32'd0);
        chk("reset_wdata", {24'd0, bus_wdata}, 32'd0);
        chk("reset_rdata", {24'd0, rdata}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst;
            cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwd;
            dbg_req = vecs[i].dreq; dbg_we = vecs[i].dwe; dbg_addr = vecs[i].daddr; dbg_wdata = vecs[i].dwd;
            bus_rdata = vecs[i].brd;
            @(posedge clk); #1;
            checks++;
            if (cpu_ack !== vecs[i].eca || dbg_ack !== vecs[i].eda || rdata !== vecs[i].erd ||
                bus_we !== vecs[i].ewe || bus_oe !== vecs[i].eoe || busy !== vecs[i].ebusy ||
                (vecs[i].ebusy && bus_addr !== vecs[i].eaddr) || (vecs[i].ewe && bus_wdata !== vecs[i].ewd)) begin
                errors++;
                $display("FAIL vec%0d: got cack=%b dack=%b rdata=%h addr=%h we=%b oe=%b wd=%h busy=%b, expected cack=%b dack=%b rdata=%h addr=%h we=%b oe=%b wd=%h busy=%b",
                    i, cpu_ack, dbg_ack, rdata, bus_addr, bus_we, bus_oe, bus_wdata, busy,
                    vecs[i].eca, vecs[i].eda, vecs[i].erd, vecs[i].eaddr, vecs[i].ewe, vecs[i].eoe, vecs[i].ewd, vecs[i].ebusy);
            end
        end

        // CPU read of 0x20; address changed and req dropped during ACCESS
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h20; bus_rdata = 8'h99;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        cpu_addr = 7'h55; cpu_req = 1'b0;
        seen = 1'b0; addr_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (busy && bus_addr !== 7'h20) addr_ok = 1'b0;
            if (cpu_ack) begin seen = 1'b1; break; end
        end
        chk("late_change_addr_held", {31'd0, addr_ok}, 32'd1);
        chk("late_change_ack", {31'd0, seen}, 32'd1);
        chk("late_change_rdata", {24'd0, rdata}, 32'h99);
        @(posedge clk); #1;
        chk("late_change_idle", {31'd0, busy}, 32'd0);

        // reset during a write's ACCESS phase
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h11; cpu_wdata = 8'hEE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_access_we", {31'd0, bus_we}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_oe_busy", {29'd0, bus_we, bus_oe, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (cpu_ack || dbg_ack || busy) seen = 1'b1;
        end
        chk("abort_no_ack", {31'd0, seen}, 32'd0);

        @(negedge clk);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h33; bus_rdata = 8'h12;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (dbg_ack) break;
        end
        chk("post_abort_latency", n, 32'd4);
        chk("post_abort_rdata", {24'd0, rdata}, 32'h12);
        @(negedge clk);
        dbg_req = 1'b0;

        // debug read latency for WAIT_CYCLES=0 and WAIT_CYCLES=15
        measure(1'b0, n, rd);
        chk("lat_wait0", n, 32'd3);
        chk("rdata_wait0", {24'd0, rd}, 32'h4E);
        measure(1'b1, n, rd);
        chk("lat_wait15", n, 32'd18);
        chk("rdata_wait15", {24'd0, rd}, 32'h4E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
